// File: rtl/udma_eth_pkg.sv
// rtl/udma_eth_pkg.sv - shared types, limits and tail-mask helper for the uDMA Ethernet TX framer
package udma_eth_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PAD,
    ST_CLOSE
  } eth_txf_state_e;

  localparam int ETH_MIN_FRAME = 60;
  localparam int ETH_MAX_FRAME = 1514;

  // Keeps bytes below len within the last little-endian word; len%4==0 keeps all four.
  function automatic logic [31:0] tail_mask(input logic [1:0] len_lsb);
    case (len_lsb)
      2'd1:    tail_mask = 32'h0000_00FF;
      2'd2:    tail_mask = 32'h0000_FFFF;
      2'd3:    tail_mask = 32'h00FF_FFFF;
      default: tail_mask = 32'hFFFF_FFFF;
    endcase
  endfunction

endpackage

// File: rtl/udma_eth_txf_outreg.sv
// rtl/udma_eth_txf_outreg.sv - single-entry output register with valid/ready handshake
module udma_eth_txf_outreg (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [31:0] next_data,
  input  logic        next_sof,
  input  logic        next_eof,
  input  logic [1:0]  next_bytes,
  input  logic        ready,
  output logic        can_load,
  output logic        valid,
  output logic [31:0] data,
  output logic        sof,
  output logic        eof,
  output logic [1:0]  bytes
);

  assign can_load = !valid || ready;

  // Payload fields only change on load, so they stay stable while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      data  <= '0;
      sof   <= 1'b0;
      eof   <= 1'b0;
      bytes <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= next_data;
      sof   <= next_sof;
      eof   <= next_eof;
      bytes <= next_bytes;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/udma_eth_tx_framer.sv
// rtl/udma_eth_tx_framer.sv - frames the raw uDMA TX word stream into padded Ethernet frames
module udma_eth_tx_framer import udma_eth_pkg::*; #(
  parameter int TRANS_SIZE      = 16,
  parameter int MIN_FRAME_BYTES = ETH_MIN_FRAME,
  parameter int MAX_FRAME_BYTES = ETH_MAX_FRAME
) (
  input  logic                  sys_clk_i,
  input  logic                  rstn_i,
  input  logic [TRANS_SIZE-1:0] cfg_frame_len_i,
  input  logic                  cfg_start_i,
  input  logic                  cfg_abort_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic [15:0]           frame_cnt_o,
  input  logic [31:0]           udma_tx_data_i,
  input  logic                  udma_tx_valid_i,
  output logic                  udma_tx_ready_o,
  output logic [31:0]           eth_tx_data_o,
  output logic                  eth_tx_valid_o,
  output logic                  eth_tx_sof_o,
  output logic                  eth_tx_eof_o,
  output logic [1:0]            eth_tx_bytes_o,
  input  logic                  eth_tx_ready_i
);

  localparam int CW = TRANS_SIZE - 1;
  typedef logic [TRANS_SIZE:0] ext_t;
  typedef logic [CW-1:0]       cnt_t;

  eth_txf_state_e state, state_next;
  cnt_t        data_words, total_words, loaded;
  logic [1:0]  len_lsb, eof_bytes;
  logic        close_loaded, done_q, err_q;
  logic [15:0] frame_cnt;

  ext_t len_ext, plen_ext;
  logic len_bad, start_ok;
  logic udma_take, eof_take, last_data, last_word;
  logic load, load_sof, load_eof, out_can_load;
  logic [31:0] load_data;
  logic [1:0]  load_bytes;

  assign len_ext  = {1'b0, cfg_frame_len_i};
  assign plen_ext = (len_ext < ext_t'(MIN_FRAME_BYTES)) ? ext_t'(MIN_FRAME_BYTES) : len_ext;
  assign len_bad  = (cfg_frame_len_i == '0) || (len_ext > ext_t'(MAX_FRAME_BYTES));
  assign start_ok = (state == ST_IDLE) && cfg_start_i && !cfg_abort_i;

  assign last_data = (loaded == data_words - 1'b1);
  assign last_word = (loaded == total_words - 1'b1);

  assign udma_tx_ready_o = (state == ST_DATA) && (loaded < data_words) && out_can_load;
  assign udma_take       = udma_tx_ready_o && udma_tx_valid_i;
  assign eof_take        = eth_tx_valid_o && eth_tx_ready_i && eth_tx_eof_o;

  always_comb begin
    load       = 1'b0;
    load_data  = '0;
    load_sof   = 1'b0;
    load_eof   = 1'b0;
    load_bytes = 2'b11;
    case (state)
      ST_DATA: if (udma_take) begin
        load      = 1'b1;
        load_data = last_data ? (udma_tx_data_i & tail_mask(len_lsb)) : udma_tx_data_i;
        load_sof  = (loaded == '0);
        load_eof  = last_word;
      end
      ST_PAD: if (out_can_load && (loaded != total_words)) begin
        load     = 1'b1;
        load_eof = last_word;
      end
      ST_CLOSE: if (out_can_load && !close_loaded) begin
        load     = 1'b1;
        load_eof = 1'b1;
      end
      default: ;
    endcase
    if (load_eof && (state != ST_CLOSE)) load_bytes = eof_bytes;
  end

  // A completed eof handshake beats a simultaneous abort; the frame is already whole.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (start_ok && !len_bad) state_next = ST_DATA;
      ST_DATA, ST_PAD: begin
        if (eof_take)
          state_next = ST_IDLE;
        else if (cfg_abort_i)
          state_next = ((loaded == '0) && !udma_take) ? ST_IDLE : ST_CLOSE;
        else if ((state == ST_DATA) && udma_take && last_data && (total_words > data_words))
          state_next = ST_PAD;
      end
      ST_CLOSE: if (eof_take && close_loaded) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state        <= ST_IDLE;
      data_words   <= '0;
      total_words  <= '0;
      loaded       <= '0;
      len_lsb      <= '0;
      eof_bytes    <= '0;
      close_loaded <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      frame_cnt    <= '0;
    end else begin
      state  <= state_next;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      if (start_ok) begin
        if (len_bad) begin
          err_q <= 1'b1;
        end else begin
          len_lsb      <= cfg_frame_len_i[1:0];
          data_words   <= cnt_t'((len_ext + ext_t'(3)) >> 2);
          total_words  <= cnt_t'((plen_ext + ext_t'(3)) >> 2);
          eof_bytes    <= plen_ext[1:0] - 2'd1;
          loaded       <= '0;
          close_loaded <= 1'b0;
        end
      end
      if (load) loaded <= loaded + 1'b1;
      if ((state == ST_CLOSE) && load) close_loaded <= 1'b1;
      if ((state != ST_IDLE) && (state_next == ST_IDLE)) begin
        if ((state != ST_CLOSE) && eof_take) begin
          done_q    <= 1'b1;
          frame_cnt <= frame_cnt + 16'd1;
        end else begin
          err_q <= 1'b1;
        end
      end
    end
  end

  assign busy_o      = (state != ST_IDLE);
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign frame_cnt_o = frame_cnt;

  udma_eth_txf_outreg u_outreg (
    .clk        (sys_clk_i),
    .rst_n      (rstn_i),
    .load       (load),
    .next_data  (load_data),
    .next_sof   (load_sof),
    .next_eof   (load_eof),
    .next_bytes (load_bytes),
    .ready      (eth_tx_ready_i),
    .can_load   (out_can_load),
    .valid      (eth_tx_valid_o),
    .data       (eth_tx_data_o),
    .sof        (eth_tx_sof_o),
    .eof        (eth_tx_eof_o),
    .bytes      (eth_tx_bytes_o)
  );

endmodule

// File: tb/tb_udma_eth_tx_framer.sv
// tb/tb_udma_eth_tx_framer.sv - directed self-checking bench for udma_eth_tx_framer
module tb_udma_eth_tx_framer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] cfg_frame_len;
  logic        cfg_start, cfg_abort;
  logic        busy, done, err;
  logic [15:0] frame_cnt;
  logic [31:0] udma_data;
  logic        udma_valid, udma_ready;
  logic [31:0] eth_data;
  logic        eth_valid, eth_sof, eth_eof;
  logic [1:0]  eth_bytes;
  logic        eth_ready;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  udma_eth_tx_framer dut (
    .sys_clk_i       (clk),
    .rstn_i          (rst_n),
    .cfg_frame_len_i (cfg_frame_len),
    .cfg_start_i     (cfg_start),
    .cfg_abort_i     (cfg_abort),
    .busy_o          (busy),
    .done_o          (done),
    .err_o           (err),
    .frame_cnt_o     (frame_cnt),
    .udma_tx_data_i  (udma_data),
    .udma_tx_valid_i (udma_valid),
    .udma_tx_ready_o (udma_ready),
    .eth_tx_data_o   (eth_data),
    .eth_tx_valid_o  (eth_valid),
    .eth_tx_sof_o    (eth_sof),
    .eth_tx_eof_o    (eth_eof),
    .eth_tx_bytes_o  (eth_bytes),
    .eth_tx_ready_i  (eth_ready)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pattern(input int i);
    logic [7:0] b;
    b = 8'(4 * i);
    return {b + 8'd3, b + 8'd2, b + 8'd1, b};
  endfunction

  function automatic logic [31:0] bmask(input int len);
    case (len % 4)
      1:       return 32'h0000_00FF;
      2:       return 32'h0000_FFFF;
      3:       return 32'h00FF_FFFF;
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  task automatic idle_outputs_zero(input string tag);
    check({tag, "_eth_valid"}, eth_valid, 0);
    check({tag, "_eth_data"}, eth_data, 0);
    check({tag, "_eth_sof"}, eth_sof, 0);
    check({tag, "_udma_ready"}, udma_ready, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_frame_cnt"}, frame_cnt, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_err"}, err, 0);
  endtask

  task automatic run_frame(input int len, input bit stalls, input int abort_after, input int exp_cnt);
    int dw, plen, tw, exp_n, src_idx, out_idx, n_done, n_err;
    bit abort_sent, hold, finished;
    logic [31:0] h_data, e_data;
    logic        h_sof, h_eof, e_sof, e_eof;
    logic [1:0]  h_bytes, e_bytes;
    dw = (len + 3) / 4;
    plen = (len < 60) ? 60 : len;
    tw = (plen + 3) / 4;
    exp_n = (abort_after >= 0) ? abort_after + 1 : tw;
    src_idx = 0; out_idx = 0; n_done = 0; n_err = 0;
    abort_sent = 0; hold = 0; finished = 0;
    h_data = '0; h_sof = 0; h_eof = 0; h_bytes = '0;
    @(negedge clk);
    cfg_frame_len = 16'(len);
    cfg_start = 1'b1;
    udma_valid = 1'b0;
    @(negedge clk);
    cfg_start = 1'b0;
    for (int cyc = 0; cyc < 4000 && !finished; cyc++) begin
      if (cyc > 0) @(negedge clk);
      cfg_abort = 1'b0;
      if (abort_after >= 0 && !abort_sent && src_idx == abort_after) begin
        cfg_abort = 1'b1;
        abort_sent = 1;
      end
      udma_valid = !abort_sent && (src_idx < dw) && (!stalls || $urandom_range(0, 3) != 0);
      udma_data = pattern(src_idx);
      eth_ready = !stalls || ($urandom_range(0, 2) != 0);
      #1;
      if (cyc == 0) check("first_ready", udma_ready, 1);
      if (hold) begin
        check("stall_valid", eth_valid, 1);
        check("stall_data", eth_data, h_data);
        check("stall_sof", eth_sof, h_sof);
        check("stall_eof", eth_eof, h_eof);
        check("stall_bytes", eth_bytes, h_bytes);
      end
      if (done) n_done++;
      if (err) n_err++;
      if (!busy) begin
        finished = 1;
      end else begin
        hold = eth_valid && !eth_ready;
        h_data = eth_data; h_sof = eth_sof; h_eof = eth_eof; h_bytes = eth_bytes;
        if (eth_valid && eth_ready) begin
          if (out_idx < exp_n) begin
            if (abort_after >= 0 && out_idx == abort_after) begin
              e_data = '0; e_sof = 0; e_eof = 1; e_bytes = 2'b11;
            end else begin
              e_data = (out_idx < dw) ?
                       (pattern(out_idx) & ((out_idx == dw - 1) ? bmask(len) : 32'hFFFF_FFFF)) : '0;
              e_sof = (out_idx == 0);
              e_eof = (out_idx == tw - 1);
              e_bytes = e_eof ? 2'((plen - 1) % 4) : 2'b11;
            end
            check($sformatf("data[%0d]", out_idx), eth_data, e_data);
            check($sformatf("sof[%0d]", out_idx), eth_sof, e_sof);
            check($sformatf("eof[%0d]", out_idx), eth_eof, e_eof);
            check($sformatf("bytes[%0d]", out_idx), eth_bytes, e_bytes);
          end else begin
            check("extra_word", out_idx, exp_n - 1);
          end
          out_idx++;
        end
        if (udma_valid && udma_ready) src_idx++;
      end
    end
    cfg_abort = 1'b0;
    udma_valid = 1'b0;
    eth_ready = 1'b1;
    check("timeout", finished, 1);
    check("word_count", out_idx, exp_n);
    check("src_count", src_idx, (abort_after >= 0) ? abort_after : dw);
    check("done_pulses", n_done, (abort_after >= 0) ? 0 : 1);
    check("err_pulses", n_err, (abort_after >= 0) ? 1 : 0);
    check("frame_cnt", frame_cnt, exp_cnt);
  endtask

  task automatic reject_len(input int len, input string tag);
    @(negedge clk);
    cfg_frame_len = 16'(len);
    cfg_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
    #1;
    check({tag, "_err"}, err, 1);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_udma_ready"}, udma_ready, 0);
    @(negedge clk);
    #1;
    check({tag, "_err_single"}, err, 0);
    check({tag, "_eth_valid"}, eth_valid, 0);
    check({tag, "_busy_after"}, busy, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    cfg_frame_len = '0;
    cfg_start = 1'b0;
    cfg_abort = 1'b0;
    udma_data = '0;
    udma_valid = 1'b0;
    eth_ready = 1'b1;
    #1;
    idle_outputs_zero("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    run_frame(64, 0, -1, 1);
    run_frame(13, 0, -1, 2);
    run_frame(1514, 1, -1, 3);

    reject_len(0, "len0");
    reject_len(1515, "len1515");
    check("reject_frame_cnt", frame_cnt, 3);

    @(negedge clk);
    cfg_frame_len = 16'd64;
    cfg_start = 1'b1;
    cfg_abort = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
    cfg_abort = 1'b0;
    #1;
    check("start_abort_busy", busy, 0);
    check("start_abort_err", err, 0);

    run_frame(100, 0, 5, 3);
    run_frame(60, 0, -1, 4);

    @(negedge clk);
    cfg_frame_len = 16'd100;
    cfg_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
    udma_valid = 1'b1;
    udma_data = 32'hDEAD_BEEF;
    repeat (4) @(negedge clk);
    check("midframe_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    idle_outputs_zero("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    udma_valid = 1'b0;
    run_frame(60, 0, -1, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
